// File: rtl/voq_req_gen.sv
// VOQ bookkeeping in front of the iSLIP arbiter.
// Keeps per-(input, output) packet counts, issues request matrices and retires grants.
module voq_req_gen #(
  parameter int PORT_NUM  = 4,
  parameter int PORT_L2   = $clog2(PORT_NUM),
  parameter int CNT_WIDTH = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORT_NUM-1:0]            enq_valid,
  input  logic [PORT_NUM*PORT_L2-1:0]    enq_dest,
  output logic [PORT_NUM-1:0]            enq_ready,
  input  logic [PORT_NUM-1:0]            out_rdy,
  output logic                           req_valid,
  input  logic                           req_ready,
  output logic [PORT_NUM*PORT_NUM-1:0]   req_vect,
  input  logic                           gnt_valid,
  output logic                           gnt_ready,
  input  logic [PORT_NUM*PORT_NUM-1:0]   gnt_vect,
  output logic                           gnt_err
);

  localparam int NN = PORT_NUM * PORT_NUM;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    REQ  = 4'b0010,
    WAIT = 4'b0100,
    UPDT = 4'b1000
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_WIDTH-1:0] cnt_reg [NN];
  logic [NN-1:0]        cnt_full;
  logic [NN-1:0]        lreq;
  logic [NN-1:0]        inc;
  logic [NN-1:0]        dec;
  logic [NN-1:0]        req_vect_reg, req_vect_next;
  logic [NN-1:0]        gnt_reg, gnt_next;
  logic [NN-1:0]        gnt_tr;
  logic [PORT_NUM-1:0]  row_multi;
  logic [PORT_NUM-1:0]  col_multi;
  logic                 gnt_bad;
  logic                 gnt_err_reg;

  genvar gi, gj;
  generate
    for (gi = 0; gi < PORT_NUM; gi++) begin : g_in
      logic [PORT_L2-1:0]  dest;
      logic [PORT_NUM-1:0] row_full;
      logic [PORT_NUM-1:0] row_gnt;
      logic [PORT_NUM-1:0] col_gnt;

      assign dest      = enq_dest[gi*PORT_L2 +: PORT_L2];
      assign row_full  = cnt_full[gi*PORT_NUM +: PORT_NUM];
      assign enq_ready[gi] = !rst && !row_full[dest];

      // x & (x-1) is nonzero exactly when x has two or more bits set
      assign row_gnt       = gnt_reg[gi*PORT_NUM +: PORT_NUM];
      assign row_multi[gi] = (row_gnt & (row_gnt - 1'b1)) != '0;
      assign col_gnt       = gnt_tr[gi*PORT_NUM +: PORT_NUM];
      assign col_multi[gi] = (col_gnt & (col_gnt - 1'b1)) != '0;

      for (gj = 0; gj < PORT_NUM; gj++) begin : g_out
        localparam int K = gi*PORT_NUM + gj;

        assign cnt_full[K]            = cnt_reg[K] == CNT_MAX;
        assign lreq[K]                = (cnt_reg[K] != '0) && out_rdy[gj];
        assign gnt_tr[gj*PORT_NUM+gi] = gnt_reg[K];
        assign inc[K] = enq_valid[gi] && enq_ready[gi] && (dest == PORT_L2'(gj));
        // only snapshot bits retire, so a decrement never sees a zero count
        assign dec[K] = (state_reg == UPDT) && gnt_reg[K] && req_vect_reg[K];

        always_ff @(posedge clk) begin
          if (rst) begin
            cnt_reg[K] <= '0;
          end else if (inc[K] && !dec[K]) begin
            cnt_reg[K] <= cnt_reg[K] + 1'b1;
          end else if (dec[K] && !inc[K]) begin
            cnt_reg[K] <= cnt_reg[K] - 1'b1;
          end
        end
      end
    end
  endgenerate

  assign gnt_bad = (|(gnt_reg & ~req_vect_reg)) || (|row_multi) || (|col_multi);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      req_vect_reg <= '0;
      gnt_reg      <= '0;
      gnt_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      req_vect_reg <= req_vect_next;
      gnt_reg      <= gnt_next;
      if (state_reg == UPDT && gnt_bad) begin
        gnt_err_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    req_vect_next = req_vect_reg;
    gnt_next      = gnt_reg;
    req_valid     = 1'b0;
    gnt_ready     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        // out_rdy only matters here; the snapshot is frozen until UPDT ends
        if (|lreq) begin
          req_vect_next = lreq;
          state_next    = REQ;
        end
      end
      REQ: begin
        req_valid = 1'b1;
        if (req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        gnt_ready = 1'b1;
        if (gnt_valid) begin
          gnt_next   = gnt_vect;
          state_next = UPDT;
        end
      end
      UPDT: begin
        req_vect_next = '0;
        gnt_next      = '0;
        state_next    = IDLE;
      end
      default: begin
        req_vect_next = '0;
        gnt_next      = '0;
        state_next    = IDLE;
      end
    endcase
  end

  assign req_vect = req_vect_reg;
  assign gnt_err  = gnt_err_reg;

endmodule

// File: tb/tb_voq_req_gen.sv
// Bench for voq_req_gen: expected request matrices go into a queue and a negedge
// monitor checks every presented matrix; directed checks cover counters and errors.
module tb_voq_req_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  enq_valid;
  logic [7:0]  enq_dest;
  logic [3:0]  enq_ready;
  logic [3:0]  out_rdy;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_vect;
  logic        gnt_valid;
  logic        gnt_ready;
  logic [15:0] gnt_vect;
  logic        gnt_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] sb[$];

  voq_req_gen #(.PORT_NUM(4), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_dest(enq_dest), .enq_ready(enq_ready),
    .out_rdy(out_rdy),
    .req_valid(req_valid), .req_ready(req_ready), .req_vect(req_vect),
    .gnt_valid(gnt_valid), .gnt_ready(gnt_ready), .gnt_vect(gnt_vect),
    .gnt_err(gnt_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // request monitor: compare whatever the DUT presents against the queue head
  always @(negedge clk) begin
    if (req_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL req_unexpected: got req_vect %h, expected no request", req_vect);
      end else begin
        chk("req_vect", {16'h0, req_vect}, {16'h0, sb[0]});
        if (req_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input int i, input int d, input logic v);
    logic [1:0] dd;
    dd = d[1:0];
    enq_valid[i] = v;
    enq_dest[i*2 +: 2] = dd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    sb.delete();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic idle_check(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      chk(name, {31'h0, req_valid}, 32'h0);
      tick();
    end
  endtask

  task automatic wait_req(output bit ok);
    for (int k = 0; k < 20 && !req_valid; k++) tick();
    ok = req_valid;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_timeout: got req_valid 0 after 20 cycles, expected 1");
    end
  endtask

  // one arbitration round: hold req_ready low, accept, grant g, optionally enqueue during UPDT
  task automatic serve(input logic [15:0] g, input int hold, input bit enq_updt,
                       input int ei, input int ed);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    repeat (hold) tick();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("gnt_ready_wait", {31'h0, gnt_ready}, 32'h1);
    gnt_valid = 1'b1;
    gnt_vect  = g;
    tick();
    gnt_valid = 1'b0;
    gnt_vect  = '0;
    if (enq_updt) set_enq(ei, ed, 1'b1);
    tick();
    if (enq_updt) set_enq(ei, ed, 1'b0);
  endtask

  initial begin
    bit ok;
    rst = 1'b1; enq_valid = '0; enq_dest = '0; out_rdy = 4'hF;
    req_ready = 1'b0; gnt_valid = 1'b0; gnt_vect = '0;

    // T1 reset
    tick(); tick();
    chk("t1_req_valid", {31'h0, req_valid}, 32'h0);
    chk("t1_gnt_ready", {31'h0, gnt_ready}, 32'h0);
    chk("t1_gnt_err", {31'h0, gnt_err}, 32'h0);
    chk("t1_enq_ready_rst", {28'h0, enq_ready}, 32'h0);
    rst = 1'b0;
    #1;
    chk("t1_enq_ready", {28'h0, enq_ready}, 32'hF);

    // T2 enqueue 0->2, two-cycle latency, stalled handshake, grant retires it
    sb.push_back(16'h0004);
    set_enq(0, 2, 1'b1);
    tick();
    set_enq(0, 2, 1'b0);
    chk("t2_lat_t1", {31'h0, req_valid}, 32'h0);
    tick();
    chk("t2_lat_t2", {31'h0, req_valid}, 32'h1);
    serve(16'h0004, 3, 1'b0, 0, 0);
    chk("t2_gnt_err", {31'h0, gnt_err}, 32'h0);
    idle_check("t2_idle", 4);

    // T3 fill VOQ 1->3 to max
    do_reset();
    sb.push_back(16'h0080);
    for (int k = 0; k < 63; k++) begin
      set_enq(1, 3, 1'b1);
      tick();
    end
    set_enq(1, 3, 1'b0);
    chk("t3_full_d3", {31'h0, enq_ready[1]}, 32'h0);
    set_enq(1, 0, 1'b0);
    #1;
    chk("t3_free_d0", {31'h0, enq_ready[1]}, 32'h1);
    set_enq(1, 3, 1'b1);
    tick();
    set_enq(1, 3, 1'b0);
    chk("t3_sat_64th", {31'h0, enq_ready[1]}, 32'h0);
    serve(16'h0080, 0, 1'b0, 0, 0);
    sb.push_back(16'h0080);
    chk("t3_after_dec", {28'h0, enq_ready}, 32'hF);
    do_reset();

    // T4 simultaneous increment and decrement on VOQ 2->1
    sb.push_back(16'h0200);
    sb.push_back(16'h0200);
    set_enq(2, 1, 1'b1);
    tick();
    set_enq(2, 1, 1'b0);
    serve(16'h0200, 0, 1'b1, 2, 1);
    serve(16'h0200, 1, 1'b0, 0, 0);
    chk("t4_gnt_err", {31'h0, gnt_err}, 32'h0);
    idle_check("t4_idle", 4);

    // T5 output 2 masked, then unmasked; later mask changes do not disturb held request
    do_reset();
    out_rdy = 4'b1011;
    set_enq(0, 2, 1'b1);
    tick();
    set_enq(0, 2, 1'b0);
    idle_check("t5_masked", 4);
    sb.push_back(16'h0004);
    out_rdy = 4'hF;
    tick();
    chk("t5_req_rise", {31'h0, req_valid}, 32'h1);
    out_rdy = 4'b1011;
    serve(16'h0004, 2, 1'b0, 0, 0);
    out_rdy = 4'hF;
    idle_check("t5_idle", 3);

    // T6 illegal grant, then reset while waiting for a grant
    do_reset();
    sb.push_back(16'h0001);
    set_enq(0, 0, 1'b1);
    tick(); tick();
    set_enq(0, 0, 1'b0);
    serve(16'h0011, 0, 1'b0, 0, 0);
    chk("t6_gnt_err_set", {31'h0, gnt_err}, 32'h1);
    sb.push_back(16'h0001);
    wait_req(ok);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("t6_in_wait", {31'h0, gnt_ready}, 32'h1);
    rst = 1'b1;
    gnt_valid = 1'b1;
    gnt_vect = 16'h0001;
    tick();
    gnt_valid = 1'b0;
    gnt_vect = '0;
    chk("t6_enq_ready_rst", {28'h0, enq_ready}, 32'h0);
    rst = 1'b0;
    #1;
    chk("t6_req_valid", {31'h0, req_valid}, 32'h0);
    chk("t6_gnt_ready", {31'h0, gnt_ready}, 32'h0);
    chk("t6_gnt_err_clr", {31'h0, gnt_err}, 32'h0);
    chk("t6_enq_ready", {28'h0, enq_ready}, 32'hF);
    idle_check("t6_idle", 4);

    chk("sb_empty", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
